// File: rtl/fd_multiciclo.sv
// rtl/fd_multiciclo.sv - multi-cycle datapath: register file, data memory, add/sub ALU, control FSM
// One micro-op in flight at a time; valid/ready accept, done pulse on completion.
module fd_multiciclo #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rw,
  input  logic [DATA_W-1:0] imm,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SUBI = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_SD   = 3'd5;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] mem  [NMEM];

  logic [2:0]        code_q;
  logic [REG_AW-1:0] ra_q, rb_q, rw_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, alu_q, ld_q;
  logic              addr_err_q;

  logic              is_mem, is_alu, addr_bad, wb_en, op_err;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] alu_nxt, wb_val, rd_a, rd_b;

  // x0 reads as zero; it is never written, so its storage stays undefined
  assign rd_a     = (ra_q == '0) ? '0 : regs[ra_q];
  assign rd_b     = (rb_q == '0) ? '0 : regs[rb_q];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign is_mem   = (code_q == OP_LD) || (code_q == OP_SD);
  assign is_alu   = (code_q <= OP_SUBI);
  assign addr     = alu_q[MEM_AW-1:0];
  assign addr_bad = |alu_q[DATA_W-1:MEM_AW];
  assign wb_en    = (state == S_WB) && (is_alu || ((code_q == OP_LD) && !addr_err_q));
  assign wb_val   = (code_q == OP_LD) ? ld_q : alu_q;
  assign op_err   = (code_q == OP_ILL) || (is_mem && addr_err_q);

  always_comb begin
    alu_nxt = a_q + imm_q;
    case (code_q)
      OP_ADD:  alu_nxt = a_q + b_q;
      OP_SUB:  alu_nxt = a_q - b_q;
      OP_SUBI: alu_nxt = a_q - imm_q;
      default: alu_nxt = a_q + imm_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = S_READ;
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:   state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      code_q     <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rw_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      ld_q       <= '0;
      addr_err_q <= 1'b0;
    end else begin
      done <= (state == S_WB);
      case (state)
        S_IDLE: if (op_valid) begin
          code_q <= op_code;
          ra_q   <= ra;
          rb_q   <= rb;
          rw_q   <= rw;
          imm_q  <= imm;
        end
        S_READ: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        S_EXEC: alu_q <= alu_nxt;
        S_MEM: begin
          addr_err_q <= addr_bad;
          ld_q       <= mem[addr];
        end
        S_WB: begin
          err <= op_err;
          if (wb_en) result <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; an async reset drops state to IDLE, which gates both enables
  always_ff @(posedge clk) begin
    if (wb_en && (rw_q != '0)) regs[rw_q] <= wb_val;
    if ((state == S_MEM) && (code_q == OP_SD) && !addr_bad) mem[addr] <= b_q;
  end

endmodule

// File: tb/tb_fd_multiciclo.sv
// tb/tb_fd_multiciclo.sv - self-checking bench for fd_multiciclo against an architectural model
module tb_fd_multiciclo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = '0;
  logic [4:0]  ra = '0, rb = '0, rw = '0, dbg_addr = '0;
  logic [63:0] imm = '0;
  logic        done, err;
  logic [63:0] result, dbg_data;

  int tests = 0;
  int fails = 0;

  logic [63:0] m_reg [32];
  logic [63:0] m_mem [32];
  logic [63:0] m_result;

  fd_multiciclo #(.DATA_W(64), .REG_AW(5), .MEM_AW(5)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .ra(ra), .rb(rb), .rw(rw), .imm(imm),
    .done(done), .err(err), .result(result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdm(input logic [4:0] r);
    return (r == 0) ? 64'd0 : m_reg[r];
  endfunction

  // Issue one op, follow it to done, and compare everything against the model
  task automatic do_op(input logic [2:0] code, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] w, input logic [63:0] im, input bit hold);
    int cyc;
    int lat;
    logic [63:0] av, bv, alu;
    bit bad, e, busy_ok;
    av = rdm(a);
    bv = rdm(b);
    case (code)
      3'd0:    alu = av + bv;
      3'd1:    alu = av - bv;
      3'd3:    alu = av - im;
      default: alu = av + im;
    endcase
    lat = (code == 4 || code == 5) ? 4 : 3;
    bad = (alu >> 5) != 0;
    e   = (code == 7) || ((code == 4 || code == 5) && bad);

    @(negedge clk);
    cyc = 0;
    while (!op_ready && cyc < 20) begin @(negedge clk); cyc++; end
    op_code = code; ra = a; rb = b; rw = w; imm = im; op_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;

    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 10 && !done) begin
      if (op_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end

    if (code <= 3) begin
      m_result = alu;
      if (w != 0) m_reg[w] = alu;
    end else if (code == 4 && !bad) begin
      m_result = m_mem[alu[4:0]];
      if (w != 0) m_reg[w] = m_mem[alu[4:0]];
    end else if (code == 5 && !bad) begin
      m_mem[alu[4:0]] = bv;
    end

    check($sformatf("latency op%0d", code), 64'(cyc), 64'(lat));
    check("busy_not_ready", {63'd0, busy_ok}, 64'd1);
    check("done", {63'd0, done}, 64'd1);
    check($sformatf("err op%0d", code), {63'd0, err}, {63'd0, e});
    check($sformatf("result op%0d", code), result, m_result);
    dbg_addr = w; #1;
    check($sformatf("dbg x%0d", w), dbg_data, rdm(w));
  endtask

  task automatic dbg_check(input logic [4:0] r, input logic [63:0] exp);
    dbg_addr = r; #1;
    check($sformatf("plan x%0d", r), dbg_data, exp);
  endtask

  initial begin
    m_result = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst done", {63'd0, done}, 64'd0);
    check("rst err", {63'd0, err}, 64'd0);
    check("rst result", result, 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("rst ready", {63'd0, op_ready}, 64'd1);

    // Fill memory and registers so the model starts fully known
    for (int i = 0; i < 32; i++) do_op(3'd5, 5'd0, 5'd0, 5'd0, 64'(i), 1'b0);
    for (int i = 1; i < 32; i++) do_op(3'd2, 5'd0, 5'd0, 5'(i), {$urandom, $urandom}, 1'b0);

    do_op(3'd2, 5'd0, 5'd0, 5'd1, 64'd10, 1'b0);  dbg_check(5'd1, 64'd10);
    do_op(3'd2, 5'd0, 5'd0, 5'd2, 64'd20, 1'b0);
    do_op(3'd0, 5'd2, 5'd1, 5'd3, 64'd0, 1'b0);   dbg_check(5'd3, 64'd30);
    do_op(3'd1, 5'd3, 5'd1, 5'd4, 64'd0, 1'b0);   dbg_check(5'd4, 64'd20);
    do_op(3'd3, 5'd0, 5'd0, 5'd8, 64'd1, 1'b0);   dbg_check(5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(3'd5, 5'd0, 5'd3, 5'd0, 64'd3, 1'b0);
    do_op(3'd5, 5'd0, 5'd4, 5'd0, 64'd4, 1'b0);
    do_op(3'd4, 5'd0, 5'd0, 5'd5, 64'd3, 1'b0);   dbg_check(5'd5, 64'd30);
    do_op(3'd4, 5'd0, 5'd0, 5'd6, 64'd4, 1'b0);   dbg_check(5'd6, 64'd20);
    check("plan ld result", result, 64'd20);
    do_op(3'd2, 5'd0, 5'd0, 5'd0, 64'd5, 1'b0);   dbg_check(5'd0, 64'd0);
    do_op(3'd7, 5'd1, 5'd2, 5'd1, 64'd99, 1'b0);  dbg_check(5'd1, 64'd10);
    do_op(3'd6, 5'd1, 5'd2, 5'd2, 64'd99, 1'b0);  dbg_check(5'd2, 64'd20);
    do_op(3'd4, 5'd0, 5'd0, 5'd7, 64'd40, 1'b0);

    // Back-to-back with op_valid held high throughout
    do_op(3'd2, 5'd4, 5'd0, 5'd9, 64'd13, 1'b1);
    do_op(3'd2, 5'd9, 5'd0, 5'd11, 64'd1, 1'b1);
    do_op(3'd0, 5'd9, 5'd11, 5'd12, 64'd0, 1'b1);
    op_valid = 1'b0;
    dbg_check(5'd9, 64'd33);
    dbg_check(5'd12, 64'd67);

    // Reset in EXEC aborts the op without done or a register write
    do_op(3'd2, 5'd0, 5'd0, 5'd10, 64'd99, 1'b0);
    @(negedge clk);
    op_code = 3'd2; ra = 5'd0; rb = 5'd0; rw = 5'd10; imm = 64'd7; op_valid = 1'b1;
    @(posedge clk); #1; op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    m_result = 64'd0;
    check("abort done", {63'd0, done}, 64'd0);
    check("abort result", result, 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("abort ready", {63'd0, op_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort no done", {63'd0, done}, 64'd0);
    end
    dbg_check(5'd10, 64'd99);

    for (int n = 0; n < 80; n++) begin
      logic [2:0] c;
      logic [4:0] a;
      logic [63:0] im;
      c = 3'($urandom_range(0, 7));
      if (c == 4 || c == 5) begin
        a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
        im = 64'($urandom_range(0, 40));
      end else begin
        a  = 5'($urandom);
        im = {$urandom, $urandom};
      end
      do_op(c, a, 5'($urandom), 5'($urandom), im, 1'($urandom));
    end
    op_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fd_multiciclo.md
Name: fd_multiciclo

Overview:
- Parametrised multi-cycle successor of the single-cycle FD datapath.
- Contains a register file, a data memory, an add/sub ALU and an internal control FSM.
- Executes one decoded micro-op at a time, accepted through a valid/ready handshake, with a done pulse on completion.
- Sits between the future instruction decoder and the datapath; a debug read port exposes the register file to benches.

Parameters:
- DATA_W, 64, datapath, immediate and memory word width.
- REG_AW, 5, register address width; NREG = 2^REG_AW.
- MEM_AW, 5, memory word-address width; depth = 2^MEM_AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  micro-op request.
- op_ready  out  1  high only in IDLE.
- op_code  in  3  0 ADD, 1 SUB, 2 ADDI, 3 SUBI, 4 LD, 5 SD, 6 NOP, 7 illegal.
- ra  in  REG_AW  source A register.
- rb  in  REG_AW  source B register / SD data register.
- rw  in  REG_AW  destination register.
- imm  in  DATA_W  two's-complement immediate / offset.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: illegal opcode or address out of range.
- result  out  DATA_W  ALU result or load data of the last completed op.
- dbg_addr  in  REG_AW  debug register select.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].

Behaviour:
- Reset (async) forces state IDLE, done=0, err=0, result=0; op_ready=1 once reset is low. Register file and memory contents are not reset.
- Handshake: an op is accepted on the edge where op_valid && op_ready. ra, rb, rw, imm and op_code are latched on that edge. op_valid while busy is ignored and produces no queueing.
- FSM states: IDLE -> READ -> EXEC -> (MEM only for LD/SD) -> WB -> IDLE.
  - READ: operand registers A=reg[ra] and B=reg[rb] are captured.
  - EXEC:
    - ADD: alu = A+B.
    - SUB: alu = A-B.
    - ADDI, LD, SD: alu = A+imm.
    - SUBI: alu = A-imm.
    - Result is registered.
  - MEM: address = alu[MEM_AW-1:0]. Address error if alu[DATA_W-1:MEM_AW] != 0.
    - SD writes mem[addr]=B.
    - LD reads mem[addr] into a registered load-data value.
    - On address error there is no memory access.
  - WB: reg[rw] is written with alu (ALU ops) or load data (LD) on the edge leaving WB. result updates on the same edge. done=1 in the cycle after that edge.
- Latency, accept edge to done high: ADD/SUB/ADDI/SUBI/NOP/illegal = 3 cycles; LD/SD = 4 cycles. Next accept is possible in the done cycle (FSM is back in IDLE).
- NOP and illegal: no register or memory write. result is unchanged. Illegal sets err=1 with done.
- LD/SD address error: err=1, done pulses, no write to reg[rw] or memory, result unchanged.
- x0 is hardwired zero: writes are discarded and reads return 0. result still shows the computed value.
- Arithmetic wraps modulo 2^DATA_W; there is no overflow flag.
- Register-file read in READ of a register written in the same cycle: writes never overlap READ, because only one op is in flight.
- dbg_data reading a register being written on the current edge shows the old value until after the edge.
- Reset mid-operation: the op is aborted. Writes not yet performed never happen; a completed memory write (SD past MEM) remains. done is not pulsed.
- err is cleared to 0 on every done that is not an error.

Test Plan:
- Reset -> done=0, err=0, result=0, op_ready=1. ADDI x1,x0,10 (op 2, imm=10): done exactly 3 cycles after accept, result=10, dbg x1=10.
- ADDI x2,x0,20; ADD x3,x2,x1 -> result=30, dbg x3=30. SUB x4,x3,x1 -> 20. SUBI x8,x0,1 -> x8=0xFFFF_FFFF_FFFF_FFFF (wrap).
- SD x3,3(x0); SD x4,4(x0), each with done 4 cycles after accept. LD x5,3(x0) -> x5=30; LD x6,4(x0) -> x6=20, result=20.
- ADDI x0,x0,5 -> done, dbg x0=0. op_code=7 -> err=1 with done, no register change. LD x7,40(x0) with MEM_AW=5 -> err=1, x7 unchanged.
- Hold op_valid high with back-to-back ops -> op_ready low for the whole op, each op accepted exactly once, no lost or duplicated writes. Check with ADDI x9,x4,13 -> x9=33.
- Accept ADDI x10,x0,7, assert reset during EXEC -> done not pulsed, dbg x10 unchanged, op_ready=1 after reset release.
